// File: rtl/issue_sched_ctrl_pkg.sv
// Shared types and encodings for the dual-issue scheduler.
package issue_sched_ctrl_pkg;

    localparam int unsigned TYPE_W = 10;
    localparam int unsigned REG_W  = 5;

    localparam logic [TYPE_W-1:0] INST_ALU  = 10'h001;
    localparam logic [TYPE_W-1:0] INST_MUL  = 10'h004;
    localparam logic [TYPE_W-1:0] INST_DIV  = 10'h008;
    localparam logic [TYPE_W-1:0] INST_ERTN = 10'h020;

    typedef enum logic [1:0] {
        S_NORM  = 2'd0,
        S_DRAIN = 2'd1,
        S_SOLO  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_ent_t;

    // True when the one-hot type selects the shared multiply/divide unit.
    function automatic logic is_muldiv(input logic [TYPE_W-1:0] t);
        return |(t & (INST_MUL | INST_DIV));
    endfunction

endpackage

// File: rtl/issue_sched_ctrl_load_use_sb.sv
// Load-use scoreboard: shift register of in-flight load destinations plus
// source compare for both buffer heads.
module load_use_sb
    import issue_sched_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             ins_v_i,
    input  logic [REG_W-1:0] ins_rd_i,
    input  logic [REG_W-1:0] h0_rs1_i,
    input  logic [REG_W-1:0] h0_rs2_i,
    input  logic [1:0]       h0_rs_use_i,
    input  logic [REG_W-1:0] h1_rs1_i,
    input  logic [REG_W-1:0] h1_rs2_i,
    input  logic [1:0]       h1_rs_use_i,
    output logic             hit0_c,
    output logic             hit1_c,
    output logic             empty_c
);

    sb_ent_t [LOAD_LAT-1:0] sb_q;
    sb_ent_t [LOAD_LAT-1:0] sb_d;

    // Flush drops every in-flight load, even while stalled.
    always_comb begin
        sb_d = sb_q;
        if (flush_i) begin
            for (int i = 0; i < int'(LOAD_LAT); i++) begin
                sb_d[i].v = 1'b0;
            end
        end else if (!stall_i) begin
            sb_d[0] = {ins_v_i, ins_rd_i};
            for (int i = 1; i < int'(LOAD_LAT); i++) begin
                sb_d[i] = sb_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        hit0_c  = 1'b0;
        hit1_c  = 1'b0;
        empty_c = 1'b1;
        for (int i = 0; i < int'(LOAD_LAT); i++) begin
            if (sb_q[i].v) begin
                empty_c = 1'b0;
                if (sb_q[i].rd != '0) begin
                    hit0_c |= (h0_rs_use_i[0] && (h0_rs1_i == sb_q[i].rd)) ||
                              (h0_rs_use_i[1] && (h0_rs2_i == sb_q[i].rd));
                    hit1_c |= (h1_rs_use_i[0] && (h1_rs1_i == sb_q[i].rd)) ||
                              (h1_rs_use_i[1] && (h1_rs2_i == sb_q[i].rd));
                end
            end
        end
    end

endmodule

// File: rtl/issue_sched_ctrl.sv
// Dual-issue scheduler between the issue buffer and the Issue->EX register.
// Optional performance counters are enabled with ISSUE_PERF_CNT_EN.
module issue_sched_ctrl
    import issue_sched_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
`ifdef ISSUE_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        h_valid,
    input  logic [TYPE_W-1:0] h0_type,
    input  logic [TYPE_W-1:0] h1_type,
    input  logic [REG_W-1:0]  h0_rs1,
    input  logic [REG_W-1:0]  h0_rs2,
    input  logic [1:0]        h0_rs_use,
    input  logic [REG_W-1:0]  h1_rs1,
    input  logic [REG_W-1:0]  h1_rs2,
    input  logic [1:0]        h1_rs_use,
    input  logic [REG_W-1:0]  h0_rd,
    input  logic [REG_W-1:0]  h1_rd,
    input  logic              h0_we,
    input  logic              h1_we,
    input  logic              h0_mem,
    input  logic              h1_mem,
    input  logic              h0_ld,
    input  logic              h1_ld,
    input  logic              h0_csr,
    input  logic              h1_csr,
    input  logic              h0_br_pd,
    input  logic              pipe_empty,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        pop_cnt,
    output logic [1:0]        issue_v,
    output logic              serial_busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_dual,
    output logic [CNT_W-1:0]  perf_single,
    output logic [CNT_W-1:0]  perf_bubble
`endif
);

    sched_state_t state_q, state_d;
    logic         serial_busy_q;
    logic         hit0_c, hit1_c, sb_empty_c;
    logic         gate_c, h0_go_c, pair_ok_c, raw_c, waw_c;
    logic         iss0_c, iss1_c, ins_v_c;
    logic [REG_W-1:0] ins_rd_c;

    load_use_sb #(.LOAD_LAT(LOAD_LAT)) u_sb (
        .clk         (clk),
        .rstn        (rstn),
        .stall_i     (stall),
        .flush_i     (flush),
        .ins_v_i     (ins_v_c),
        .ins_rd_i    (ins_rd_c),
        .h0_rs1_i    (h0_rs1),
        .h0_rs2_i    (h0_rs2),
        .h0_rs_use_i (h0_rs_use),
        .h1_rs1_i    (h1_rs1),
        .h1_rs2_i    (h1_rs2),
        .h1_rs_use_i (h1_rs_use),
        .hit0_c      (hit0_c),
        .hit1_c      (hit1_c),
        .empty_c     (sb_empty_c)
    );

    // Issue decision: head0 per FSM mode, head1 only as an independent partner in S_NORM.
    always_comb begin
        gate_c  = ~stall & ~flush;
        h0_go_c = 1'b0;
        case (state_q)
            S_NORM:  h0_go_c = h_valid[0] & ~hit0_c & ~h0_csr;
            S_SOLO:  h0_go_c = h_valid[0] & ~hit0_c;
            default: h0_go_c = 1'b0;
        endcase
        raw_c = h0_we & (h0_rd != '0) &
                ((h1_rs_use[0] & (h1_rs1 == h0_rd)) | (h1_rs_use[1] & (h1_rs2 == h0_rd)));
        waw_c = h0_we & h1_we & (h0_rd == h1_rd);
        pair_ok_c = h_valid[1] & ~raw_c & ~waw_c & ~(h0_mem & h1_mem) &
                    ~(is_muldiv(h0_type) & is_muldiv(h1_type)) &
                    ~h1_csr & ~h0_br_pd & ~hit1_c & (state_q == S_NORM);
        iss0_c   = gate_c & h0_go_c;
        iss1_c   = iss0_c & pair_ok_c;
        ins_v_c  = (iss0_c & h0_ld) | (iss1_c & h1_ld);
        ins_rd_c = (iss0_c & h0_ld) ? h0_rd : h1_rd;
    end

    assign issue_v     = {iss1_c, iss0_c};
    assign pop_cnt     = {1'b0, iss0_c} + {1'b0, iss1_c};
    assign serial_busy = serial_busy_q;

    // Serializing-instruction drain sequence.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_NORM;
        end else if (!stall) begin
            case (state_q)
                S_NORM:  if (h_valid[0] && h0_csr) state_d = S_DRAIN;
                S_DRAIN: if (pipe_empty && sb_empty_c) state_d = S_SOLO;
                S_SOLO:  if (iss0_c) state_d = S_NORM;
                default: state_d = S_NORM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_NORM;
            serial_busy_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            serial_busy_q <= (state_d != S_NORM);
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] dual_q, single_q, bubble_q;

    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dual_q   <= '0;
            single_q <= '0;
            bubble_q <= '0;
        end else if (!stall && h_valid[0]) begin
            case (pop_cnt)
                2'd2:    dual_q   <= dual_q + CNT_W'(1);
                2'd1:    single_q <= single_q + CNT_W'(1);
                default: bubble_q <= bubble_q + CNT_W'(1);
            endcase
        end
    end

    assign perf_dual   = dual_q;
    assign perf_single = single_q;
    assign perf_bubble = bubble_q;
`endif

endmodule

// File: tb/tb_issue_sched_ctrl.sv
// Scoreboard bench for issue_sched_ctrl: driver queues expected outputs per
// cycle, monitor pops and compares on the falling edge.
module tb_issue_sched_ctrl;
    import issue_sched_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        h_valid;
    logic [TYPE_W-1:0] h0_type, h1_type;
    logic [REG_W-1:0]  h0_rs1, h0_rs2, h1_rs1, h1_rs2, h0_rd, h1_rd;
    logic [1:0]        h0_rs_use, h1_rs_use;
    logic              h0_we, h1_we, h0_mem, h1_mem, h0_ld, h1_ld;
    logic              h0_csr, h1_csr, h0_br_pd, pipe_empty, stall, flush;
    logic [1:0]        pop_cnt, issue_v;
    logic              serial_busy;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]       perf_dual, perf_single, perf_bubble;
`endif

    issue_sched_ctrl dut (
        .clk(clk), .rstn(rstn), .h_valid(h_valid),
        .h0_type(h0_type), .h1_type(h1_type),
        .h0_rs1(h0_rs1), .h0_rs2(h0_rs2), .h0_rs_use(h0_rs_use),
        .h1_rs1(h1_rs1), .h1_rs2(h1_rs2), .h1_rs_use(h1_rs_use),
        .h0_rd(h0_rd), .h1_rd(h1_rd), .h0_we(h0_we), .h1_we(h1_we),
        .h0_mem(h0_mem), .h1_mem(h1_mem), .h0_ld(h0_ld), .h1_ld(h1_ld),
        .h0_csr(h0_csr), .h1_csr(h1_csr), .h0_br_pd(h0_br_pd),
        .pipe_empty(pipe_empty), .stall(stall), .flush(flush),
        .pop_cnt(pop_cnt), .issue_v(issue_v), .serial_busy(serial_busy)
`ifdef ISSUE_PERF_CNT_EN
        , .perf_dual(perf_dual), .perf_single(perf_single), .perf_bubble(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [4:0] e;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({pop_cnt, issue_v, serial_busy} !== e) begin
                errors++;
                $display("FAIL %s: got pop=%0d iv=%b busy=%b, want pop=%0d iv=%b busy=%b",
                         n, pop_cnt, issue_v, serial_busy, e[4:3], e[2:1], e[0]);
            end
        end
    end

    task automatic clr();
        h_valid = 2'b00;
        h0_type = INST_ALU; h1_type = INST_ALU;
        h0_rs1 = '0; h0_rs2 = '0; h1_rs1 = '0; h1_rs2 = '0;
        h0_rs_use = 2'b00; h1_rs_use = 2'b00;
        h0_rd = '0; h1_rd = '0; h0_we = 1'b0; h1_we = 1'b0;
        h0_mem = 1'b0; h1_mem = 1'b0; h0_ld = 1'b0; h1_ld = 1'b0;
        h0_csr = 1'b0; h1_csr = 1'b0; h0_br_pd = 1'b0;
        pipe_empty = 1'b1; stall = 1'b0; flush = 1'b0;
    endtask

    // Independent ALU pair: h0 writes r3, h1 reads r4 and writes r6.
    task automatic pair();
        clr();
        h_valid = 2'b11;
        h0_rd = 5'd3; h0_we = 1'b1;
        h1_rs1 = 5'd4; h1_rs_use = 2'b01; h1_rd = 5'd6; h1_we = 1'b1;
    endtask

    task automatic load0(input logic [REG_W-1:0] rd);
        clr();
        h_valid = 2'b01; h0_rd = rd; h0_we = 1'b1; h0_mem = 1'b1; h0_ld = 1'b1;
    endtask

    task automatic csr_head();
        clr();
        h_valid = 2'b01; h0_csr = 1'b1; h0_type = INST_ERTN;
    endtask

    task automatic chk(input logic [1:0] p, input logic [1:0] iv, input logic b, input string n);
        exp_q.push_back({p, iv, b});
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk(2'd0, 2'b00, 1'b0, "reset_empty");
        rstn = 1'b1;

        pair();                                          chk(2'd2, 2'b11, 1'b0, "dual_indep");
        pair(); h1_rs2 = 5'd5; h1_rs_use = 2'b10; h0_rd = 5'd5;
                                                         chk(2'd1, 2'b01, 1'b0, "raw");
        clr(); h_valid = 2'b01; h0_rs2 = 5'd5; h0_rs_use = 2'b10;
                                                         chk(2'd1, 2'b01, 1'b0, "raw_follow");
        pair(); h1_rs_use = 2'b00; h0_rd = 5'd9; h1_rd = 5'd9;
                                                         chk(2'd1, 2'b01, 1'b0, "waw");
        pair(); h0_mem = 1'b1; h1_mem = 1'b1;            chk(2'd1, 2'b01, 1'b0, "two_mem");
        pair(); h0_type = INST_MUL; h1_type = INST_DIV;  chk(2'd1, 2'b01, 1'b0, "two_muldiv");
        pair(); h0_br_pd = 1'b1;                         chk(2'd1, 2'b01, 1'b0, "br_pd");
        pair(); h1_csr = 1'b1;                           chk(2'd1, 2'b01, 1'b0, "h1_csr");

        load0(5'd7);                                     chk(2'd1, 2'b01, 1'b0, "load7");
        clr(); h_valid = 2'b01; h0_rs1 = 5'd7; h0_rs_use = 2'b01;
        chk(2'd0, 2'b00, 1'b0, "ld_use_1");
        chk(2'd0, 2'b00, 1'b0, "ld_use_2");
        chk(2'd1, 2'b01, 1'b0, "ld_use_rel");

        load0(5'd0);                                     chk(2'd1, 2'b01, 1'b0, "load_r0");
        clr(); h_valid = 2'b01; h0_rs1 = 5'd0; h0_rs_use = 2'b01;
                                                         chk(2'd1, 2'b01, 1'b0, "r0_no_hit");
        load0(5'd8);                                     chk(2'd1, 2'b01, 1'b0, "load8");
        clr(); h_valid = 2'b11; h1_rs1 = 5'd8; h1_rs_use = 2'b01;
                                                         chk(2'd1, 2'b01, 1'b0, "h1_ld_use");
        clr();                                           chk(2'd0, 2'b00, 1'b0, "empty_1");
        clr(); h0_rs1 = 5'd8; h0_rs_use = 2'b01;         chk(2'd0, 2'b00, 1'b0, "empty_2");

        // Drain sequence
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b0, "csr_enter");
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b1, "drain_1");
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b1, "drain_2");
        csr_head();                                      chk(2'd0, 2'b00, 1'b1, "drain_exit");
        pair(); h0_csr = 1'b1; h0_type = INST_ERTN;      chk(2'd1, 2'b01, 1'b1, "solo");
        pair();                                          chk(2'd2, 2'b11, 1'b0, "back_norm");

        // Flush while draining with a load in flight
        load0(5'd10);                                    chk(2'd1, 2'b01, 1'b0, "load10");
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b0, "csr_enter2");
        csr_head(); pipe_empty = 1'b0; flush = 1'b1;     chk(2'd0, 2'b00, 1'b1, "flush_drain");
        pair(); flush = 1'b1;                            chk(2'd0, 2'b00, 1'b0, "flush_hold");
        pair();                                          chk(2'd2, 2'b11, 1'b0, "post_flush");

        // Flush and stall together: flush must still clear state and scoreboard
        load0(5'd11);                                    chk(2'd1, 2'b01, 1'b0, "load11");
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b0, "csr_enter3");
        csr_head(); pipe_empty = 1'b0; flush = 1'b1; stall = 1'b1;
                                                         chk(2'd0, 2'b00, 1'b1, "flush_stall");
        clr(); h_valid = 2'b01; h0_rs1 = 5'd11; h0_rs_use = 2'b01;
                                                         chk(2'd1, 2'b01, 1'b0, "sb_cleared");

        // Stall freezes the scoreboard
        load0(5'd12);                                    chk(2'd1, 2'b01, 1'b0, "load12");
        for (int i = 0; i < 4; i++) begin
            pair(); h1_rs1 = 5'd12; stall = 1'b1;        chk(2'd0, 2'b00, 1'b0, "stall");
        end
        pair(); h1_rs1 = 5'd12;                          chk(2'd1, 2'b01, 1'b0, "stall_frozen_sb");
        pair();                                          chk(2'd2, 2'b11, 1'b0, "stall_release");

        // Reset in the middle of a drain
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b0, "csr_enter4");
        csr_head(); pipe_empty = 1'b0;                   chk(2'd0, 2'b00, 1'b1, "drain_pre_rst");
        csr_head(); pipe_empty = 1'b0; rstn = 1'b0;      chk(2'd0, 2'b00, 1'b1, "rst_in_drain");
        rstn = 1'b1;
        pair();                                          chk(2'd2, 2'b11, 1'b0, "after_rst");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
